stage_monitor: RTL and testbench
================================

# stage_monitor

Passive checker and decoder on the write-enable strobes from the multicycle stage controller. Each instruction must produce a fixed 9-cycle strobe sequence. The monitor rebuilds the current stage slot from the strobes, counts retired instructions, and latches a sticky error with a code and slot on the first protocol violation. It sits beside the controller in the core and in simulation benches, and never drives the datapath.

## Interface
- CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W)
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- stage_reset_n  in  1  controller's datapath reset; 0 means the controller is in INIT
- pc_wren, wb_if_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren, ram_wren, reg_wren  in  1 each  strobes under check
- err_clr  in  1  single-cycle request to clear the error and resynchronise
- stage_code  out  4  decoded slot: 0..8; 4'hD halted, 4'hE resync, 4'hF unarmed
- instr_start  out  1  one-cycle pulse on every slot-1 (if_id) acceptance
- retired  out  CNT_W  count of completed wb_if slots
- err  out  1  sticky violation flag
- err_code  out  3  0 none, 1 RESET, 2 MULTI, 3 PC, 4 ORDER
- err_slot  out  4  stage_code value at the moment the violation was captured

## Operation
- Expected strobe per slot:
  - 0: none
  - 1: if_id
  - 2: none
  - 3: id_ex
  - 4: ex_mem
  - 5: ram
  - 6: mem_wb
  - 7: reg
  - 8: wb_if, with pc_wren optional alongside it
- After slot 8 the next slot is 0.
- States:
  - UNARMED: the reset state.
  - TRACK(slot): follows the sequence one slot per cycle.
  - RESYNC: waits for a realignment point after err_clr.
  - HALT: entered on error.
- UNARMED:
  - stage_reset_n=0: stay.
  - Any strobe asserted while stage_reset_n=0: error RESET, go to HALT.
  - stage_reset_n=1: the current cycle is checked as slot 0; go to TRACK(1).
- TRACK(s): compare the strobe vector against slot s, then advance to s+1 mod 9.
- RESYNC: stay until a cycle with only if_id asserted. That cycle counts as slot 1 (instr_start pulses); go to TRACK(2). Other vectors are ignored without error.
- stage_reset_n=0 in TRACK or RESYNC: go to UNARMED. That same cycle is also checked for the RESET error.
- Violation priority, highest first, evaluated in TRACK:
  1. RESET
  2. MULTI: two or more of the 7 non-pc strobes asserted.
  3. PC: pc_wren asserted in any slot other than 8.
  4. ORDER: a single strobe that does not match the slot, a missing expected strobe, or any strobe in slot 0 or 2.
- On the first violation:
  - err=1; err_code and err_slot are captured.
  - Go to HALT; retired freezes.
  - Later violations do not overwrite the captured code or slot.
- HALT: exits only via err_clr or reset_n.
- err_clr, in any state: err=0, err_code=0, err_slot=0; go to RESYNC. retired is preserved. err_clr takes priority over checking in the same cycle.
- retired increments by 1 for each accepted, error-free slot-8 cycle, and wraps from all-ones to 0.

## Timing
- All outputs are registered. They reflect the input cycle N at cycle N+1.
- Reset values: stage_code=4'hF, instr_start=0, retired=0, err=0, err_code=0, err_slot=0.
- err rises one cycle after the offending input cycle.
- stage_code shows 4'hD from that same cycle onward.
- instr_start is high for exactly one cycle, one cycle after the if_id input.
- Throughput: one full instruction per 9 cycles. retired updates one cycle after wb_if.
- reset_n dominates everything. Asserting it mid-instruction returns the monitor to UNARMED with all outputs at reset values on the next cycle.

## Test plan
- Nominal run:
  - Stimulus: stage_reset_n low for 2 cycles, then 3 correct 9-cycle sequences.
  - Required: err=0; retired goes 0→1→2→3; stage_code steps 0..8 repeatedly; instr_start pulses 3 times, 9 cycles apart.
- MULTI:
  - Stimulus: ex_mem and ram both asserted in slot 4.
  - Required: next cycle err=1, err_code=2, err_slot=4, stage_code=4'hD; retired stays frozen.
- PC:
  - Stimulus: pc_wren alone in slot 3.
  - Required: err_code=3, err_slot=3.
  - Also: pc_wren together with wb_if in slot 8 raises no error.
- ORDER:
  - Stimulus: mem_wb in slot 5 where ram was expected.
  - Required: err_code=4, err_slot=5.
  - Then an err_clr pulse followed by a clean if_id-only cycle: err=0, instr_start pulses, tracking resumes at slot 2, and retired has kept its prior value.
- RESET:
  - Stimulus: reg_wren asserted while stage_reset_n=0.
  - Required: err_code=1, err_slot=4'hF.
- Wrap and mid-run reset:
  - Stimulus: CNT_W=4 with 16 clean instructions.
  - Required: retired returns to 0.
  - Then reset_n low in slot 6: next cycle stage_code=4'hF and retired=0.

Source files
------------

// File: rtl/stage_monitor_if.sv
// Strobe bundle from the multicycle stage controller, as seen by stage_monitor.
// The controller drives through master; monitors only ever listen through slave.
interface stage_monitor_if;
    logic stage_reset_n;
    logic pc_wren;
    logic wb_if_wren;
    logic if_id_wren;
    logic id_ex_wren;
    logic ex_mem_wren;
    logic mem_wb_wren;
    logic ram_wren;
    logic reg_wren;

    modport master (
        output stage_reset_n, pc_wren, wb_if_wren, if_id_wren, id_ex_wren,
               ex_mem_wren, mem_wb_wren, ram_wren, reg_wren
    );

    modport slave (
        input  stage_reset_n, pc_wren, wb_if_wren, if_id_wren, id_ex_wren,
               ex_mem_wren, mem_wb_wren, ram_wren, reg_wren
    );
endinterface

// File: rtl/stage_monitor.sv
// Passive checker for the 9-slot write-enable strobe sequence: rebuilds the slot,
// counts retired instructions and latches the first protocol violation.
module stage_monitor #(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    stage_monitor_if.slave    strb,
    input  logic              err_clr,
    output logic [3:0]        stage_code,
    output logic              instr_start,
    output logic [CNT_W-1:0]  retired,
    output logic              err,
    output logic [2:0]        err_code,
    output logic [3:0]        err_slot
);

    typedef enum logic [1:0] {
        ST_UNARMED = 2'd0,
        ST_TRACK   = 2'd1,
        ST_RESYNC  = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    localparam logic [3:0] CODE_HALT    = 4'hD;
    localparam logic [3:0] CODE_RESYNC  = 4'hE;
    localparam logic [3:0] CODE_UNARMED = 4'hF;
    localparam logic [3:0] SLOT_FIRST   = 4'd1;
    localparam logic [3:0] SLOT_LAST    = 4'd8;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_RESET = 3'd1;
    localparam logic [2:0] ERR_MULTI = 3'd2;
    localparam logic [2:0] ERR_PC    = 3'd3;
    localparam logic [2:0] ERR_ORDER = 3'd4;

    // Strobe vector bit order: {wb_if, reg, mem_wb, ram, ex_mem, id_ex, if_id}
    function automatic logic [6:0] expected_strobe(input logic [3:0] slot);
        logic [6:0] exp_v;
        case (slot)
            4'd1:    exp_v = 7'b000_0001;
            4'd3:    exp_v = 7'b000_0010;
            4'd4:    exp_v = 7'b000_0100;
            4'd5:    exp_v = 7'b000_1000;
            4'd6:    exp_v = 7'b001_0000;
            4'd7:    exp_v = 7'b010_0000;
            4'd8:    exp_v = 7'b100_0000;
            default: exp_v = 7'b000_0000;
        endcase
        return exp_v;
    endfunction

    function automatic logic multi_hot(input logic [6:0] v);
        return (v & (v - 7'd1)) != 7'd0;
    endfunction

    // Highest-priority violation for a cycle that is checked against a slot.
    function automatic logic [2:0] classify(input logic [3:0] slot, input logic pc,
                                            input logic [6:0] v);
        logic [2:0] c;
        if (multi_hot(v)) begin
            c = ERR_MULTI;
        end else if (pc && (slot != SLOT_LAST)) begin
            c = ERR_PC;
        end else if (v != expected_strobe(slot)) begin
            c = ERR_ORDER;
        end else begin
            c = ERR_NONE;
        end
        return c;
    endfunction

    state_t             state_r, state_n;
    logic [3:0]         slot_r, slot_n;
    logic [3:0]         stage_code_r, stage_code_n;
    logic               instr_start_r, instr_start_n;
    logic [CNT_W-1:0]   retired_r, retired_n;
    logic               err_r, err_n;
    logic [2:0]         err_code_r, err_code_n;
    logic [3:0]         err_slot_r, err_slot_n;

    logic [6:0]         strobe_s;
    logic               any_strobe_s;
    logic               if_id_only_s;
    logic [3:0]         check_slot_s;
    logic [2:0]         viol_s;
    logic               cap_s;
    logic [2:0]         cap_code_s;
    logic [3:0]         cap_slot_s;

    assign strobe_s = {strb.wb_if_wren, strb.reg_wren, strb.mem_wb_wren, strb.ram_wren,
                       strb.ex_mem_wren, strb.id_ex_wren, strb.if_id_wren};
    assign any_strobe_s = (|strobe_s) | strb.pc_wren;
    assign if_id_only_s = (strobe_s == 7'b000_0001) && !strb.pc_wren;
    // An arming cycle out of UNARMED is judged as slot 0.
    assign check_slot_s = (state_r == ST_UNARMED) ? 4'd0 : slot_r;
    assign viol_s = classify(check_slot_s, strb.pc_wren, strobe_s);

    // Next-state, violation capture and next output values.
    always_comb begin
        state_n       = state_r;
        slot_n        = slot_r;
        stage_code_n  = stage_code_r;
        instr_start_n = 1'b0;
        retired_n     = retired_r;
        err_n         = err_r;
        err_code_n    = err_code_r;
        err_slot_n    = err_slot_r;
        cap_s         = 1'b0;
        cap_code_s    = ERR_NONE;
        cap_slot_s    = 4'd0;

        case (state_r)
            ST_UNARMED: begin
                if (!strb.stage_reset_n) begin
                    stage_code_n = CODE_UNARMED;
                    if (any_strobe_s) begin
                        cap_s      = 1'b1;
                        cap_code_s = ERR_RESET;
                        cap_slot_s = CODE_UNARMED;
                    end else begin
                        cap_s = 1'b0;
                    end
                end else if (viol_s != ERR_NONE) begin
                    cap_s      = 1'b1;
                    cap_code_s = viol_s;
                    cap_slot_s = 4'd0;
                end else begin
                    state_n      = ST_TRACK;
                    slot_n       = SLOT_FIRST;
                    stage_code_n = 4'd0;
                end
            end
            ST_TRACK: begin
                if (!strb.stage_reset_n) begin
                    if (any_strobe_s) begin
                        cap_s      = 1'b1;
                        cap_code_s = ERR_RESET;
                        cap_slot_s = slot_r;
                    end else begin
                        state_n      = ST_UNARMED;
                        stage_code_n = CODE_UNARMED;
                    end
                end else if (viol_s != ERR_NONE) begin
                    cap_s      = 1'b1;
                    cap_code_s = viol_s;
                    cap_slot_s = slot_r;
                end else begin
                    stage_code_n  = slot_r;
                    instr_start_n = (slot_r == SLOT_FIRST);
                    if (slot_r == SLOT_LAST) begin
                        slot_n    = 4'd0;
                        retired_n = retired_r + CNT_W'(1);
                    end else begin
                        slot_n = slot_r + 4'd1;
                    end
                end
            end
            ST_RESYNC: begin
                if (!strb.stage_reset_n) begin
                    if (any_strobe_s) begin
                        cap_s      = 1'b1;
                        cap_code_s = ERR_RESET;
                        cap_slot_s = CODE_RESYNC;
                    end else begin
                        state_n      = ST_UNARMED;
                        stage_code_n = CODE_UNARMED;
                    end
                end else if (if_id_only_s) begin
                    // Realignment point: this cycle is slot 1 of a fresh instruction.
                    state_n       = ST_TRACK;
                    slot_n        = 4'd2;
                    stage_code_n  = SLOT_FIRST;
                    instr_start_n = 1'b1;
                end else begin
                    stage_code_n = CODE_RESYNC;
                end
            end
            ST_HALT: begin
                stage_code_n = CODE_HALT;
            end
            default: begin
                state_n      = ST_UNARMED;
                stage_code_n = CODE_UNARMED;
            end
        endcase

        if (cap_s) begin
            state_n       = ST_HALT;
            stage_code_n  = CODE_HALT;
            instr_start_n = 1'b0;
            retired_n     = retired_r;
            err_n         = 1'b1;
            err_code_n    = cap_code_s;
            err_slot_n    = cap_slot_s;
        end else begin
            err_n = err_r;
        end

        // Clearing wins over whatever this cycle's check concluded.
        if (err_clr) begin
            state_n       = ST_RESYNC;
            slot_n        = slot_r;
            stage_code_n  = CODE_RESYNC;
            instr_start_n = 1'b0;
            retired_n     = retired_r;
            err_n         = 1'b0;
            err_code_n    = ERR_NONE;
            err_slot_n    = 4'd0;
        end else begin
            slot_n = slot_n;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r       <= ST_UNARMED;
            slot_r        <= 4'd0;
            stage_code_r  <= CODE_UNARMED;
            instr_start_r <= 1'b0;
            retired_r     <= '0;
            err_r         <= 1'b0;
            err_code_r    <= ERR_NONE;
            err_slot_r    <= 4'd0;
        end else begin
            state_r       <= state_n;
            slot_r        <= slot_n;
            stage_code_r  <= stage_code_n;
            instr_start_r <= instr_start_n;
            retired_r     <= retired_n;
            err_r         <= err_n;
            err_code_r    <= err_code_n;
            err_slot_r    <= err_slot_n;
        end
    end

    assign stage_code  = stage_code_r;
    assign instr_start = instr_start_r;
    assign retired     = retired_r;
    assign err         = err_r;
    assign err_code    = err_code_r;
    assign err_slot    = err_slot_r;

endmodule

// File: tb/tb_stage_monitor.sv
// Self-checking bench for stage_monitor: directed protocol scenarios plus random
// strobe traffic, both checked every cycle against a behavioural model.
module tb_stage_monitor;

    localparam logic [7:0] IF_ID  = 8'h01;
    localparam logic [7:0] ID_EX  = 8'h02;
    localparam logic [7:0] EX_MEM = 8'h04;
    localparam logic [7:0] RAM    = 8'h08;
    localparam logic [7:0] MEM_WB = 8'h10;
    localparam logic [7:0] REG    = 8'h20;
    localparam logic [7:0] WB_IF  = 8'h40;
    localparam logic [7:0] PC     = 8'h80;
    // Required non-pc strobe for each slot 0..8.
    localparam logic [7:0] WANT [9] = '{8'h00, IF_ID, 8'h00, ID_EX, EX_MEM, RAM, MEM_WB, REG, WB_IF};

    localparam int M_UNARMED = 0;
    localparam int M_TRACK   = 1;
    localparam int M_RESYNC  = 2;
    localparam int M_HALT    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        err_clr;
    stage_monitor_if bus();

    logic [3:0]  sc32, sc4, slot32, slot4;
    logic        start32, start4, err32, err4;
    logic [31:0] ret32;
    logic [3:0]  ret4;
    logic [2:0]  code32, code4;

    stage_monitor #(.CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .strb(bus), .err_clr(err_clr),
        .stage_code(sc32), .instr_start(start32), .retired(ret32),
        .err(err32), .err_code(code32), .err_slot(slot32)
    );

    stage_monitor #(.CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .strb(bus), .err_clr(err_clr),
        .stage_code(sc4), .instr_start(start4), .retired(ret4),
        .err(err4), .err_code(code4), .err_slot(slot4)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic chk_en = 1'b0;

    // Model state and expected outputs (n_* pending for the next edge, e_* current).
    int          m_mode;
    int          m_pos;
    logic [3:0]  n_sc, e_sc, n_slot, e_slot;
    logic        n_start, e_start, n_err, e_err;
    logic [31:0] n_ret, e_ret;
    logic [2:0]  n_code, e_code;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_UNARMED; m_pos = 0;
        n_sc = 4'hF; n_start = 1'b0; n_ret = 32'd0;
        n_err = 1'b0; n_code = 3'd0; n_slot = 4'd0;
    endtask

    task automatic model_fail(input int c, input int where);
        n_err = 1'b1; n_code = 3'(c); n_slot = 4'(where);
        n_sc = 4'hD; m_mode = M_HALT;
    endtask

    task automatic model_step(input logic srn, input logic clr, input logic [7:0] v);
        int s;
        int viol;
        n_start = 1'b0;
        if (clr) begin
            m_mode = M_RESYNC; n_err = 1'b0; n_code = 3'd0; n_slot = 4'd0; n_sc = 4'hE;
        end else if (m_mode == M_HALT) begin
            n_sc = 4'hD;
        end else if (!srn) begin
            if (v != 8'h00)
                model_fail(1, (m_mode == M_UNARMED) ? 15 : ((m_mode == M_TRACK) ? m_pos : 14));
            else begin
                m_mode = M_UNARMED; n_sc = 4'hF;
            end
        end else if (m_mode == M_RESYNC) begin
            if (v == IF_ID) begin
                m_mode = M_TRACK; m_pos = 2; n_sc = 4'd1; n_start = 1'b1;
            end else
                n_sc = 4'hE;
        end else begin
            s = (m_mode == M_UNARMED) ? 0 : m_pos;
            if ($countones(v[6:0]) >= 2)          viol = 2;
            else if (v[7] && s != 8)              viol = 3;
            else if ({1'b0, v[6:0]} != WANT[s])   viol = 4;
            else                                  viol = 0;
            if (viol != 0)
                model_fail(viol, s);
            else begin
                n_sc = 4'(s);
                n_start = (s == 1);
                if (s == 8) n_ret = n_ret + 32'd1;
                m_pos = (s + 1) % 9;
                m_mode = M_TRACK;
            end
        end
    endtask

    task automatic latch_expect();
        e_sc = n_sc; e_start = n_start; e_ret = n_ret;
        e_err = n_err; e_code = n_code; e_slot = n_slot;
    endtask

    task automatic set_bus(input logic srn, input logic [7:0] v);
        bus.stage_reset_n = srn;
        bus.if_id_wren = v[0]; bus.id_ex_wren = v[1]; bus.ex_mem_wren = v[2];
        bus.ram_wren = v[3]; bus.mem_wb_wren = v[4]; bus.reg_wren = v[5];
        bus.wb_if_wren = v[6]; bus.pc_wren = v[7];
    endtask

    task automatic drive(input logic srn, input logic clr, input logic [7:0] v);
        reset_n = 1'b1; err_clr = clr;
        set_bus(srn, v);
        model_step(srn, clr, v);
        @(posedge clk); #1;
        cyc++;
        latch_expect();
    endtask

    task automatic do_reset(input int n, input logic [7:0] v);
        reset_n = 1'b0; err_clr = 1'b0;
        set_bus(1'b1, v);
        model_reset();
        repeat (n) begin
            @(posedge clk); #1;
            cyc++;
        end
        latch_expect();
        reset_n = 1'b1;
    endtask

    task automatic run_slots(input int from, input int to);
        for (int s = from; s <= to; s++) drive(1'b1, 1'b0, WANT[s]);
    endtask

    // Compare process: both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stage_code", 32'(sc32), 32'(e_sc));
            chk("instr_start", 32'(start32), 32'(e_start));
            chk("retired", ret32, e_ret);
            chk("err", 32'(err32), 32'(e_err));
            chk("err_code", 32'(code32), 32'(e_code));
            chk("err_slot", 32'(slot32), 32'(e_slot));
            chk("retired_w4", 32'(ret4), 32'(e_ret[3:0]));
            chk("stage_code_w4", 32'(sc4), 32'(e_sc));
            chk("err_code_w4", 32'(code4), 32'(e_code));
        end
    end

    initial begin
        int pulses;
        int last_pulse;
        logic [7:0] v;
        logic srn, clr;

        do_reset(2, 8'h00);
        chk_en = 1'b1;
        chk("reset_stage_code", 32'(sc32), 32'hF);
        chk("reset_retired", ret32, 32'd0);

        // Nominal: two INIT cycles then three clean instructions.
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        pulses = 0; last_pulse = 0;
        for (int i = 0; i < 3; i++) begin
            for (int s = 0; s <= 8; s++) begin
                drive(1'b1, 1'b0, WANT[s]);
                if (i == 0 && s == 0) chk("nominal_first_slot", 32'(sc32), 32'd0);
                if (start32) begin
                    if (pulses > 0) chk("pulse_spacing", 32'(cyc - last_pulse), 32'd9);
                    pulses++; last_pulse = cyc;
                end
            end
            chk("nominal_retired", ret32, 32'(i + 1));
        end
        chk("nominal_pulses", 32'(pulses), 32'd3);

        // MULTI in slot 4.
        run_slots(0, 3);
        drive(1'b1, 1'b0, EX_MEM | RAM);
        chk("multi_err", 32'(err32), 32'd1);
        chk("multi_code", 32'(code32), 32'd2);
        chk("multi_slot", 32'(slot32), 32'd4);
        chk("multi_halt", 32'(sc32), 32'hD);
        drive(1'b1, 1'b0, WB_IF);
        chk("multi_frozen", ret32, 32'd3);

        // PC alone in slot 3, then pc alongside wb_if in slot 8 is legal.
        drive(1'b1, 1'b1, 8'h00);
        chk("clr_err", 32'(err32), 32'd0);
        chk("clr_resync", 32'(sc32), 32'hE);
        drive(1'b1, 1'b0, IF_ID);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, PC);
        chk("pc_code", 32'(code32), 32'd3);
        chk("pc_slot", 32'(slot32), 32'd3);
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b0, IF_ID);
        run_slots(2, 7);
        drive(1'b1, 1'b0, WB_IF | PC);
        chk("pc_slot8_ok", 32'(err32), 32'd0);
        chk("pc_slot8_retired", ret32, 32'd4);

        // ORDER: mem_wb where ram is due, then clear and resynchronise.
        run_slots(0, 4);
        drive(1'b1, 1'b0, MEM_WB);
        chk("order_code", 32'(code32), 32'd4);
        chk("order_slot", 32'(slot32), 32'd5);
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b0, IF_ID);
        chk("resync_err", 32'(err32), 32'd0);
        chk("resync_start", 32'(start32), 32'd1);
        chk("resync_slot1", 32'(sc32), 32'd1);
        chk("resync_retired", ret32, 32'd4);
        drive(1'b1, 1'b0, 8'h00);
        chk("resync_slot2", 32'(sc32), 32'd2);

        // RESET: strobe while the controller is in INIT.
        do_reset(1, 8'h00);
        drive(1'b0, 1'b0, REG);
        chk("reset_err_code", 32'(code32), 32'd1);
        chk("reset_err_slot", 32'(slot32), 32'hF);

        // Counter wrap on the 4-bit instance, then reset_n during slot 6.
        do_reset(1, 8'h00);
        for (int i = 0; i < 16; i++) run_slots(0, 8);
        chk("wrap_w4", 32'(ret4), 32'd0);
        chk("wrap_w32", ret32, 32'd16);
        run_slots(0, 5);
        do_reset(1, MEM_WB);
        chk("midreset_code", 32'(sc32), 32'hF);
        chk("midreset_retired", ret32, 32'd0);

        // Random traffic: mostly legal sequences with sparse faults and events.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset(1, 8'($urandom_range(0, 255)));
            end else begin
                srn = ($urandom_range(0, 99) >= 2);
                clr = (m_mode == M_HALT) ? ($urandom_range(0, 3) == 0)
                                         : ($urandom_range(0, 299) == 0);
                if (!srn)
                    v = ($urandom_range(0, 9) < 3) ? 8'($urandom_range(0, 255)) : 8'h00;
                else if (m_mode == M_RESYNC)
                    v = ($urandom_range(0, 1) == 0) ? IF_ID : 8'($urandom_range(0, 255));
                else if ($urandom_range(0, 99) < 4)
                    v = 8'($urandom_range(0, 255));
                else begin
                    v = WANT[(m_mode == M_TRACK) ? m_pos : 0];
                    if (m_mode == M_TRACK && m_pos == 8 && $urandom_range(0, 1) == 1) v = v | PC;
                end
                drive(srn, clr, v);
            end
        end

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
